// File: rtl/rf_pkg.sv
// Shared definitions for the register-file access controller.
// Contents: register-file geometry, length codes for partial writes,
// and the writer selector used by the round-robin pointer.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    // Length codes understood by the register file (3 also means word)
    localparam logic [1:0] LEN_WORD = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_BYTE = 2'd2;

    // Which writer wins the next wb/ld collision
    typedef enum logic {
        RR_WB = 1'b0,
        RR_LD = 1'b1
    } rr_sel_e;

endpackage

// File: rtl/rf_hazard_cmp.sv
// Read-after-write address comparator for one writer.
// Ports:
//   wr_valid  - writer has a pending request
//   wr_addr   - writer destination register
//   rd_addr_a - read source register A
//   rd_addr_b - read source register B
//   hit       - pending write targets one of the read sources
// x0 is hard-wired to zero in the register file, so a write to it never
// creates a dependency.
module rf_hazard_cmp
    import rf_pkg::*;
(
    input  logic                  wr_valid,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic                  hit
);

    assign hit = wr_valid
              && (wr_addr != {REG_ADDR_W{1'b0}})
              && ((wr_addr == rd_addr_a) || (wr_addr == rd_addr_b));

endmodule

// File: rtl/regfile_access_ctrl.sv
// Arbiter between ALU writeback (wb), load writeback (ld) and operand
// read (rd) for a register file that does one write or one dual read
// per cycle, with registered read data.
// Ports:
//   wb_*   - ALU writeback request (valid/ready, addr, data)
//   ld_*   - load writeback request (valid/ready, addr, data, length)
//   rd_*   - operand read request (valid/ready, two source addresses)
//   rsp_*  - read response (valid/ready, two operands)
//   rf_*   - register file control/data (combinational out, registered in)
// Grants are combinational; only the round-robin pointer, the read
// starvation counter and the response valid flag are state.
module regfile_access_ctrl
    import rf_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_addr,
    input  logic [XLEN-1:0]       ld_data,
    input  logic [1:0]            ld_len,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [XLEN-1:0]       rsp_data_a,
    output logic [XLEN-1:0]       rsp_data_b,
    output logic                  rf_wr_en,
    output logic                  rf_rd_en,
    output logic [REG_ADDR_W-1:0] rf_write_address,
    output logic [REG_ADDR_W-1:0] rf_address_a,
    output logic [REG_ADDR_W-1:0] rf_address_b,
    output logic [XLEN-1:0]       rf_write_data,
    output logic [1:0]            rf_data_length,
    input  logic [XLEN-1:0]       rf_data_a,
    input  logic [XLEN-1:0]       rf_data_b
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] ONE_C      = WAIT_W'(1);

    logic              wb_hit_s;
    logic              ld_hit_s;
    logic              haz_s;
    logic              rd_blk_s;
    logic              force_rd_s;
    logic              wb_gnt_s;
    logic              ld_gnt_s;
    logic              rd_gnt_s;
    rr_sel_e           rr_q;
    rr_sel_e           rr_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic              rsp_valid_q;
    logic              rsp_valid_d;

    rf_hazard_cmp u_haz_wb (
        .wr_valid  (wb_valid),
        .wr_addr   (wb_addr),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .hit       (wb_hit_s)
    );

    rf_hazard_cmp u_haz_ld (
        .wr_valid  (ld_valid),
        .wr_addr   (ld_addr),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .hit       (ld_hit_s)
    );

    assign haz_s      = rd_valid && (wb_hit_s || ld_hit_s);
    // The register file output is overwritten by the next read, so an
    // unconsumed response must block further reads.
    assign rd_blk_s   = haz_s || (rsp_valid_q && !rsp_ready);
    assign force_rd_s = rd_valid && !rd_blk_s && (wait_q == MAX_WAIT_C);

    // Grant selection: starved read, then writers (round-robin), then read
    always_comb begin
        wb_gnt_s = 1'b0;
        ld_gnt_s = 1'b0;
        rd_gnt_s = 1'b0;
        if (!rst_n) begin
            // requests are dropped while reset is held
            rd_gnt_s = 1'b0;
        end else if (force_rd_s) begin
            rd_gnt_s = 1'b1;
        end else if (ld_valid && (!wb_valid || (rr_q == RR_LD))) begin
            ld_gnt_s = 1'b1;
        end else if (wb_valid) begin
            wb_gnt_s = 1'b1;
        end else if (rd_valid && !rd_blk_s) begin
            rd_gnt_s = 1'b1;
        end else begin
            rd_gnt_s = 1'b0;
        end
    end

    // Register-file command mux driven by the winning request
    always_comb begin
        rf_wr_en         = 1'b0;
        rf_rd_en         = 1'b0;
        rf_write_address = {REG_ADDR_W{1'b0}};
        rf_address_a     = {REG_ADDR_W{1'b0}};
        rf_address_b     = {REG_ADDR_W{1'b0}};
        rf_write_data    = {XLEN{1'b0}};
        rf_data_length   = LEN_WORD;
        if (wb_gnt_s) begin
            rf_wr_en         = 1'b1;
            rf_write_address = wb_addr;
            rf_write_data    = wb_data;
        end else if (ld_gnt_s) begin
            rf_wr_en         = 1'b1;
            rf_write_address = ld_addr;
            rf_write_data    = ld_data;
            rf_data_length   = ld_len;
        end else if (rd_gnt_s) begin
            rf_rd_en     = 1'b1;
            rf_address_a = rd_addr_a;
            rf_address_b = rd_addr_b;
        end else begin
            rf_wr_en = 1'b0;
        end
    end

    // Next-state for round-robin pointer, starvation counter, response flag
    always_comb begin
        rr_d        = rr_q;
        wait_d      = wait_q;
        rsp_valid_d = rsp_valid_q;

        if (wb_gnt_s) begin
            rr_d = RR_LD;
        end else if (ld_gnt_s) begin
            rr_d = RR_WB;
        end else begin
            rr_d = rr_q;
        end

        if (!rd_valid || rd_gnt_s) begin
            wait_d = {WAIT_W{1'b0}};
        end else if (wait_q != MAX_WAIT_C) begin
            wait_d = wait_q + ONE_C;
        end else begin
            wait_d = wait_q;
        end

        // A new grant wins over consumption so back-to-back reads keep valid high
        if (rd_gnt_s) begin
            rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= RR_WB;
            wait_q      <= {WAIT_W{1'b0}};
            rsp_valid_q <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign wb_ready   = wb_gnt_s;
    assign ld_ready   = ld_gnt_s;
    assign rd_ready   = rd_gnt_s;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data_a = rf_data_a;
    assign rsp_data_b = rf_data_b;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural register file.
module tb_regfile_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic [1:0]  ld_len;
    logic        rd_valid, rd_ready;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data_a, rsp_data_b;
    logic        rf_wr_en, rf_rd_en;
    logic [4:0]  rf_write_address, rf_address_a, rf_address_b;
    logic [31:0] rf_write_data;
    logic [1:0]  rf_data_length;
    logic [31:0] rf_data_a, rf_data_b;

    int errors = 0;
    int checks = 0;

    regfile_access_ctrl #(.MAX_WAIT(4), .WAIT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_len(ld_len),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
        .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
        .rf_write_address(rf_write_address), .rf_address_a(rf_address_a),
        .rf_address_b(rf_address_b), .rf_write_data(rf_write_data),
        .rf_data_length(rf_data_length), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: x0 reads zero, partial writes zero-extend
    logic [31:0] mem [32];
    bit          mem_init = 1'b0;

    function automatic logic [31:0] rf_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        return mem[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_data_a <= 32'h0;
            rf_data_b <= 32'h0;
            if (!mem_init) begin
                for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
                mem_init <= 1'b1;
            end
        end else begin
            if (rf_wr_en && rf_write_address != 5'd0) begin
                case (rf_data_length)
                    2'd2:    mem[rf_write_address] <= {24'h0, rf_write_data[7:0]};
                    2'd1:    mem[rf_write_address] <= {16'h0, rf_write_data[15:0]};
                    default: mem[rf_write_address] <= rf_write_data;
                endcase
            end
            if (rf_rd_en) begin
                rf_data_a <= rf_rd(rf_address_a);
                rf_data_b <= rf_rd(rf_address_b);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clr_inputs();
        wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
        ld_valid = 1'b0; ld_addr = 5'd0; ld_data = 32'h0; ld_len = 2'd0;
        rd_valid = 1'b0; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        rsp_ready = 1'b1;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Expected grant pattern for the wb/ld collision test
    logic exp_wb [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        clr_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        settle();
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_wr_en", {31'h0, rf_wr_en}, 32'h0);
        chk("rst_rd_en", {31'h0, rf_rd_en}, 32'h0);
        chk("rst_waddr", {27'h0, rf_write_address}, 32'h0);
        chk("rst_wdata", rf_write_data, 32'h0);

        // 1: write then dependent read
        tick();
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        rd_valid = 1'b1; rd_addr_a = 5'd5; rd_addr_b = 5'd0;
        settle();
        chk("t1_wb_ready", {31'h0, wb_ready}, 32'h1);
        chk("t1_rd_blocked", {31'h0, rd_ready}, 32'h0);
        chk("t1_wdata", rf_write_data, 32'hDEADBEEF);
        chk("t1_waddr", {27'h0, rf_write_address}, 32'd5);
        tick();
        wb_valid = 1'b0;
        settle();
        chk("t1_rd_en", {31'h0, rf_rd_en}, 32'h1);
        chk("t1_raddr_a", {27'h0, rf_address_a}, 32'd5);
        chk("t1_no_wr", {31'h0, rf_wr_en}, 32'h0);
        tick();
        rd_valid = 1'b0;
        settle();
        chk("t1_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        chk("t1_rsp_a", rsp_data_a, 32'hDEADBEEF);
        chk("t1_rsp_b", rsp_data_b, 32'h0);
        tick();
        settle();
        chk("t1_rsp_drop", {31'h0, rsp_valid}, 32'h0);

        // 2: wb/ld round-robin
        do_reset();
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h11111111;
        ld_valid = 1'b1; ld_addr = 5'd4; ld_data = 32'hAABBCCDD; ld_len = 2'd2;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t2_wb_ready", {31'h0, wb_ready}, {31'h0, exp_wb[i]});
            chk("t2_ld_ready", {31'h0, ld_ready}, {31'h0, ~exp_wb[i]});
            chk("t2_waddr", {27'h0, rf_write_address}, exp_wb[i] ? 32'd3 : 32'd4);
            chk("t2_len", {30'h0, rf_data_length}, exp_wb[i] ? 32'd0 : 32'd2);
            tick();
        end
        clr_inputs();

        // 3: starved read forced on the 5th cycle, counter restarts
        do_reset();
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77777777;
        rd_valid = 1'b1; rd_addr_a = 5'd1; rd_addr_b = 5'd2;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("t3_rd_ready", {31'h0, rd_ready}, (i == 4) ? 32'h1 : 32'h0);
            chk("t3_wr_en", {31'h0, rf_wr_en}, (i == 4) ? 32'h0 : 32'h1);
            tick();
        end
        clr_inputs();

        // 4: RAW hazard blocks even a starved read; x0 never stalls
        do_reset();
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h99999999;
        rd_valid = 1'b1; rd_addr_a = 5'd9; rd_addr_b = 5'd1;
        for (int i = 0; i < 7; i++) begin
            settle();
            chk("t4_haz_block", {31'h0, rd_ready}, 32'h0);
            tick();
        end
        wb_valid = 1'b0;
        settle();
        chk("t4_rd_after_drop", {31'h0, rd_ready}, 32'h1);
        tick();
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h5A5A5A5A;
        rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t4_x0_rd_ready", {31'h0, rd_ready}, (i == 4) ? 32'h1 : 32'h0);
            tick();
        end
        clr_inputs();

        // 5: back-pressured response stalls second read, then back-to-back
        do_reset();
        rsp_ready = 1'b0;
        rd_valid = 1'b1; rd_addr_a = 5'd3; rd_addr_b = 5'd4;
        settle();
        chk("t5_first_rd", {31'h0, rd_ready}, 32'h1);
        tick();
        rd_addr_a = 5'd5; rd_addr_b = 5'd3;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t5_stall", {31'h0, rd_ready}, 32'h0);
            chk("t5_hold_valid", {31'h0, rsp_valid}, 32'h1);
            chk("t5_hold_a", rsp_data_a, 32'h11111111);
            chk("t5_hold_b", rsp_data_b, 32'h000000DD);
            tick();
        end
        rsp_ready = 1'b1;
        settle();
        chk("t5_b2b_rd", {31'h0, rd_ready}, 32'h1);
        tick();
        rd_valid = 1'b0;
        settle();
        chk("t5_b2b_valid", {31'h0, rsp_valid}, 32'h1);
        chk("t5_b2b_a", rsp_data_a, 32'hDEADBEEF);
        chk("t5_b2b_b", rsp_data_b, 32'h11111111);
        tick();
        clr_inputs();

        // 6: reset mid-operation
        do_reset();
        wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'h12345678;
        settle();
        chk("t6_wb", {31'h0, wb_ready}, 32'h1);
        tick();
        wb_valid = 1'b0;
        rsp_ready = 1'b0;
        rd_valid = 1'b1; rd_addr_a = 5'd10; rd_addr_b = 5'd0;
        settle();
        chk("t6_rd", {31'h0, rd_ready}, 32'h1);
        tick();
        rd_valid = 1'b0;
        wb_valid = 1'b1;
        ld_valid = 1'b1; ld_addr = 5'd11; ld_data = 32'hCAFEF00D; ld_len = 2'd0;
        settle();
        chk("t6_pre_rsp", {31'h0, rsp_valid}, 32'h1);
        chk("t6_pre_data", rsp_data_a, 32'h12345678);
        chk("t6_rr_ld", {31'h0, ld_ready}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_rsp", {31'h0, rsp_valid}, 32'h0);
        chk("t6_rst_wr_en", {31'h0, rf_wr_en}, 32'h0);
        chk("t6_rst_ld", {31'h0, ld_ready}, 32'h0);
        chk("t6_rst_wb", {31'h0, wb_ready}, 32'h0);
        tick();
        rst_n = 1'b1;
        settle();
        chk("t6_post_wb", {31'h0, wb_ready}, 32'h1);
        chk("t6_post_ld", {31'h0, ld_ready}, 32'h0);
        tick();
        clr_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Arbitrates the single-operation-per-cycle register file between two writers and one reader: core ALU writeback (wb), load-return writeback (ld) and operand read (rd).
- The register file performs either one write or one dual read per clock, and its read data is registered.
- This block issues wr_en/rd_en, addresses and data to the register file.
- It enforces read-after-write ordering and returns read data to the requester through a valid/ready response.

Parameters:
- MAX_WAIT, 4: consecutive cycles a pending read may lose to writes before it is forced ahead of them (range 1..15).
- WAIT_W, 4: width of the read-starvation counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wb_valid  in  1  ALU writeback request
- wb_ready  out  1  wb request accepted this cycle
- wb_addr  in  5  wb destination register
- wb_data  in  32  wb write data
- ld_valid  in  1  load writeback request
- ld_ready  out  1  ld request accepted this cycle
- ld_addr  in  5  ld destination register
- ld_data  in  32  ld write data
- ld_len  in  2  write length: 2=byte[7:0], 1=half[15:0], 0/3=word
- rd_valid  in  1  operand read request
- rd_ready  out  1  read accepted this cycle
- rd_addr_a  in  5  source register A
- rd_addr_b  in  5  source register B
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  consumer takes the read data
- rsp_data_a  out  32  operand A
- rsp_data_b  out  32  operand B
- rf_wr_en  out  1  register file write enable
- rf_rd_en  out  1  register file read enable
- rf_write_address  out  5  write address
- rf_address_a  out  5  read address A
- rf_address_b  out  5  read address B
- rf_write_data  out  32  write data
- rf_data_length  out  2  length code to register file
- rf_data_a  in  32  register file registered output A
- rf_data_b  in  32  register file registered output B

Behaviour:
- Reset is asynchronous and active-low on rst_n; the clock is clk.
- Reset values:
  - rsp_valid=0.
  - Round-robin pointer = wb-first.
  - Wait counter = 0.
  - All rf_* outputs are combinational; with no valids they are 0.
- Grants are combinational from the valids and the registered state. At most one of wb_ready, ld_ready and rd_ready is high per cycle; a transfer is valid&&ready.
- rf_wr_en and rf_rd_en are never both high.

Hazard:
- haz = rd_valid && ((wb_valid && wb_addr!=0 && wb_addr∈{rd_addr_a, rd_addr_b}) || (the same test for ld)).
- While haz is high, the read is never granted.

Read blocked:
- rd_blk = haz || (rsp_valid && !rsp_ready).
- The register file output holds only until the next rf_rd_en, so an unconsumed response blocks new reads.

Priority:
1. Forced read: rd_valid && !rd_blk && wait_cnt==MAX_WAIT → read is granted.
2. Otherwise, if any writer is valid → write. When wb and ld are both valid, the writer is chosen round-robin; the pointer flips to the other writer after every write grant.
3. Otherwise, rd_valid && !rd_blk → read.

Datapath:
- Write grant: rf_wr_en=1 with the winner's addr and data. rf_data_length = ld_len for ld, 0 for wb.
- Writes to x0 are still issued; the register file discards them.
- Read grant: rf_rd_en=1, rf_address_a/b = rd_addr_a/b.

Wait counter:
- Increments, saturating at MAX_WAIT, on every cycle rd_valid is high and not granted.
- Clears on a read grant or when rd_valid is low.

Response:
- rsp_valid is set at the clock edge that performs the read grant, giving 1-cycle latency.
- It is cleared on rsp_valid && rsp_ready unless a new read is granted in the same cycle (back-to-back reads are allowed when rsp_ready=1).
- rsp_data_a/b = rf_data_a/b, passed through directly; they are held stable while rsp_valid && !rsp_ready.

Reset mid-operation:
- Pending requests are dropped, rsp_valid clears, and the register file clears its outputs concurrently.

Decomposition:
- Shared package rf_pkg:
  - Length codes LEN_WORD=0, LEN_HALF=1, LEN_BYTE=2.
  - REG_ADDR_W=5, XLEN=32.
- Sub-module rf_hazard_cmp: a combinational address-match of one writer against both read addresses, including the x0 exclusion. It is instantiated twice (wb, ld).

Test Plan:
1. wb_valid, wb_addr=5, wb_data=0xDEADBEEF, then rd_valid with a=5, b=0 → write in cycle 0; rf_rd_en in cycle 1; rsp_valid in cycle 2 with rsp_data_a=0xDEADBEEF, rsp_data_b=0.
2. wb (addr 3) and ld (addr 4) both valid for 4 cycles → grants alternate wb, ld, wb, ld; ld_len=2 drives rf_data_length=2.
3. wb_valid held continuously to addr 7, rd_valid with a=1, b=2 → the read is granted on the 5th cycle with MAX_WAIT=4, and the wait counter returns to 0.
4. wb_valid to addr 9 held, rd_addr_a=9 → the read is never granted while wb is pending; when wb drops, the read is granted the next cycle; a write to addr 0 with rd_addr_a=0 causes no stall.
5. Read granted with rsp_ready=0 for 3 cycles and a second read pending → the second read is stalled; rsp_data is stable; on rsp_ready=1 the second read is granted in the same cycle and rsp_valid stays high.
6. rst_n asserted low while rsp_valid=1 and wb_valid=1 → rsp_valid=0 and rf_wr_en=0 immediately; after release, the first grant goes to wb.
